tt_ctl_driver: RTL
==================

# tt_ctl_driver

Sequencer that drives the mux-control pads (`ctl[2:0]`: select-reset, select-increment, enable) from the controller side. It takes a project address and replays the pad-level selection protocol the multiplexer controller consumes: drop enable, pulse select-reset, clock the address counter with N increment pulses, then optionally re-enable. It sits in the board-side bring-up FPGA and the chip-level testbench, with its outputs wired to the `ctl` input pads.

## Interface
- `AW`, 10: width of the project address / increment count.
- `HALF`, 4: clock cycles per increment-pulse phase (high and low) and per guard gap; must be ≥1.
- `RST_CYCLES`, 8: clock cycles `ctl_sel_rst_n` is held low; must be ≥1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_addr`  in  AW  target project address = number of increment pulses.
- `cmd_ena`  in  1  assert `ctl_ena` after selection.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse on return to IDLE.
- `ctl_sel_rst_n`  out  1  mux address counter reset, active-low.
- `ctl_sel_inc`  out  1  mux address counter increment.
- `ctl_ena`  out  1  enable selected project.

## Operation
- All `ctl_*`, `done`, and `busy` outputs are registered. `cmd_ready` = (state == IDLE).
- Reset values: state IDLE, `ctl_sel_rst_n`=0, `ctl_sel_inc`=0, `ctl_ena`=0, `done`=0, `busy`=0. `ctl_sel_rst_n` stays 0 in IDLE until the first command completes its RST phase.
- A command is accepted on a rising edge with `cmd_valid & cmd_ready`. `cmd_addr` and `cmd_ena` are latched at that edge. Later input changes have no effect.
- States:
  - **DIS** (HALF cycles): `ctl_ena`=0, `ctl_sel_rst_n` holds its previous value.
  - **RST** (RST_CYCLES cycles): `ctl_sel_rst_n`=0.
  - **GAP** (HALF cycles): `ctl_sel_rst_n`=1.
  - If the latched addr is 0, go to FIN. Otherwise go to INC_H.
  - **INC_H** (HALF cycles): `ctl_sel_inc`=1.
  - **INC_L** (HALF cycles): `ctl_sel_inc`=0, then decrement the remaining count. If it reaches 0, go to FIN; otherwise go back to INC_H.
  - **FIN** (1 cycle): `ctl_ena`=latched `cmd_ena`. Then go to IDLE with `done`=1 for exactly the first IDLE cycle.
- After a completed command, `ctl_ena` and `ctl_sel_rst_n` (=1) hold in IDLE until the next command or reset.
- Phase counter width is clog2(max(HALF, RST_CYCLES))+1. Increment counter width is AW, so the maximum addr 2^AW−1 is handled without wrap.
- `ctl_sel_inc` is never high outside INC_H. `ctl_sel_rst_n` is never low while `ctl_sel_inc` is high.
- `ctl_ena` is never high during DIS through INC_L.

## Timing
- Accept at edge T. DIS outputs appear at T+1.
- FIN occupies cycle T+1+HALF+RST_CYCLES+HALF+2·HALF·addr.
- `done` is high and `cmd_ready` returns to 1 on the following cycle.
- Total accept-to-ready latency L = 2·HALF + RST_CYCLES + 2·HALF·addr + 2 cycles. With defaults and addr=3, L = 42.
- Back-to-back commands: `cmd_valid` held high is accepted in the `done` cycle. Minimum spacing is L cycles.
- `rst` asserted mid-sequence immediately forces all outputs to their reset values (asynchronously), including `ctl_sel_inc`=0 mid-pulse. State returns to IDLE and no `done` is issued.
- `cmd_valid` while busy is ignored. No queueing.

## Test plan
- **Reset:** assert `rst` → all outputs 0 except `cmd_ready`=1. Release `rst` → `ctl_sel_rst_n` stays 0 and no pulses occur for 100 cycles.
- **Select addr=3, ena=1 (defaults):**
  - 3 `ctl_sel_inc` pulses, each 4 cycles high and 4 cycles low.
  - `ctl_sel_rst_n` low for exactly 8 cycles.
  - `ctl_ena` rises at accept+41.
  - `done` pulses at accept+42.
- **addr=0, ena=1:** zero increment pulses; `ctl_ena`=1 at accept+17; `done` at accept+18.
- **Reselect:** addr=5 ena=1, then addr=2 ena=0.
  - `ctl_ena` drops at accept2+1 and stays 0 afterwards.
  - Second command gives exactly 2 pulses.
  - `cmd_valid` held high → second accept in the `done` cycle.
- **Mid-operation reset:** addr=1023, `rst` asserted during the 500th INC_H.
  - `ctl_sel_inc` falls with no clock edge needed.
  - No `done` pulse.
  - Next command addr=1 produces exactly 1 pulse.
- **Protocol monitor, random addr/ena × 200 commands:**
  - Increment-pulse count equals addr.
  - `ctl_sel_inc` is never high while `ctl_sel_rst_n`=0 or `ctl_ena`=1.
  - `cmd_valid` during busy is never accepted.

Source files
------------

// File: rtl/tt_ctl_driver_if.sv
// rtl/tt_ctl_driver_if.sv - command and ctl-pad bundle for tt_ctl_driver
// Purpose: groups the select command handshake, status and mux-control pads.
// Ports (no ports; signals only):
//   cmd_valid/cmd_ready/cmd_addr/cmd_ena  command handshake (master drives valid/addr/ena)
//   busy/done                             sequencer status
//   ctl_sel_rst_n/ctl_sel_inc/ctl_ena     mux-control pad outputs
// master = command issuer, slave = the driver.
interface tt_ctl_driver_if #(
  parameter int AW = 10
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_ena;
  logic          busy;
  logic          done;
  logic          ctl_sel_rst_n;
  logic          ctl_sel_inc;
  logic          ctl_ena;

  modport master (
    output cmd_valid, cmd_addr, cmd_ena,
    input  cmd_ready, busy, done, ctl_sel_rst_n, ctl_sel_inc, ctl_ena
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_ena,
    output cmd_ready, busy, done, ctl_sel_rst_n, ctl_sel_inc, ctl_ena
  );
endinterface

// File: rtl/tt_ctl_driver.sv
// rtl/tt_ctl_driver.sv - mux-control pad sequencer for project selection
// Purpose: on an accepted command, drops enable, pulses select-reset, issues
// cmd_addr increment pulses, then drives enable from the latched cmd_ena.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  tt_ctl_driver_if.slave: command handshake, busy/done, ctl pads
module tt_ctl_driver #(
  parameter int AW         = 10,
  parameter int HALF       = 4,
  parameter int RST_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  tt_ctl_driver_if.slave     bus
);

  localparam int PMAX = (HALF > RST_CYCLES) ? HALF : RST_CYCLES;
  localparam int CW   = $clog2(PMAX) + 1;

  typedef enum logic [2:0] {
    IDLE, DIS, RST, GAP, INC_H, INC_L, FIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;       // cycles left in the current phase, minus one
  logic [AW-1:0] rem;       // increment pulses still to issue
  logic          ena_l;
  logic          busy_r;
  logic          done_r;
  logic          sel_rst_n_r;
  logic          sel_inc_r;
  logic          ena_r;
  logic          last;

  assign last              = (cnt == '0);
  assign bus.cmd_ready     = (state == IDLE);
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.ctl_sel_rst_n = sel_rst_n_r;
  assign bus.ctl_sel_inc   = sel_inc_r;
  assign bus.ctl_ena       = ena_r;

  // Outputs are updated on the edge that enters each state, so every pad
  // value is registered and aligned with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      ena_l       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sel_rst_n_r <= 1'b0;
      sel_inc_r   <= 1'b0;
      ena_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.cmd_valid) begin
            state  <= DIS;
            cnt    <= CW'(HALF - 1);
            rem    <= bus.cmd_addr;
            ena_l  <= bus.cmd_ena;
            busy_r <= 1'b1;
            ena_r  <= 1'b0;
          end
        end
        DIS: begin
          if (last) begin
            state       <= RST;
            cnt         <= CW'(RST_CYCLES - 1);
            sel_rst_n_r <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RST: begin
          if (last) begin
            state       <= GAP;
            cnt         <= CW'(HALF - 1);
            sel_rst_n_r <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (last) begin
            if (rem == '0) begin
              state <= FIN;
              ena_r <= ena_l;
            end else begin
              state     <= INC_H;
              cnt       <= CW'(HALF - 1);
              sel_inc_r <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        INC_H: begin
          if (last) begin
            state     <= INC_L;
            cnt       <= CW'(HALF - 1);
            sel_inc_r <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        INC_L: begin
          if (last) begin
            rem <= rem - 1'b1;
            // rem==1 here means the pulse just finished was the final one.
            if (rem == AW'(1)) begin
              state <= FIN;
              ena_r <= ena_l;
            end else begin
              state     <= INC_H;
              cnt       <= CW'(HALF - 1);
              sel_inc_r <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIN: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
